div8bits: RTL and testbench

Sequential restoring divider: divides an 8-bit unsigned dividend by a 4-bit unsigned divisor and returns an 8-bit quotient and a 4-bit remainder. It is the inverse of the team's shift-and-add multiplier and uses the same init/done handshake, so a top level can drive both units from one control FSM. It processes one quotient bit per two clock cycles.

---
 rtl/div8bits.sv | 74 +++++++
 tb/tb_div8bits.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div8bits.sv
// div8bits: sequential restoring divider, 8-bit dividend by 4-bit divisor,
// one quotient bit per SHIFT/SUB pair with an init/done handshake.
module div8bits (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DD,
  input  logic [3:0] DR,
  input  logic       init,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       zero
);
  typedef enum logic [1:0] {START, SHIFT, SUB, END1} state_t;
  state_t state, next;
  logic [7:0] q_reg;
  logic [4:0] r_acc;
  logic [3:0] d;
  logic [2:0] count;
  assign busy = state != START;
  always_comb begin
    next = START;
    case (state)
      START: next = init ? (|DR ? SHIFT : END1) : START;
      SHIFT: next = SUB;
      SUB:   next = count == 3'd7 ? END1 : SHIFT;
      default: next = START;
    endcase
  end
  // r_acc stays below d before each shift, so the dropped carry is always 0
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= START;
      q_reg       <= '0;
      r_acc       <= '0;
      d           <= '0;
      count       <= '0;
      Q           <= '0;
      R           <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      zero        <= 1'b0;
    end else begin
      state <= next;
      case (state)
        START: if (init) begin
          d           <= DR;
          q_reg       <= |DR ? DD : 8'hFF;
          r_acc       <= '0;
          count       <= '0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          zero        <= 1'b0;
        end
        SHIFT: {r_acc, q_reg} <= {r_acc[3:0], q_reg, 1'b0};
        SUB: begin
          if (r_acc >= {1'b0, d}) begin
            r_acc    <= r_acc - {1'b0, d};
            q_reg[0] <= 1'b1;
          end
          count <= count + 3'd1;
        end
        default: begin
          Q           <= q_reg;
          R           <= r_acc[3:0];
          done        <= 1'b1;
          zero        <= q_reg == 8'd0;
          div_by_zero <= d == 4'd0;
        end
      endcase
    end
endmodule

// File: tb/tb_div8bits.sv
// tb_div8bits: randomized and directed checks of div8bits against plain arithmetic.
module tb_div8bits;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] DD = '0;
  logic [3:0] DR = '0;
  logic init = 1'b0;
  logic [7:0] Q;
  logic [3:0] R;
  logic busy, done, div_by_zero, zero;
  int checks = 0;
  int errors = 0;

  div8bits dut (.clk(clk), .rst(rst), .DD(DD), .DR(DR), .init(init), .Q(Q), .R(R),
                .busy(busy), .done(done), .div_by_zero(div_by_zero), .zero(zero));

  always #5 clk = ~clk;

  function automatic int exp_q(input int dd, input int dr);
    return dr == 0 ? 255 : dd / dr;
  endfunction
  function automatic int exp_r(input int dd, input int dr);
    return dr == 0 ? 0 : dd % dr;
  endfunction

  // pulse init for one accepted edge, then count edges until done (bounded)
  task automatic run(input logic [7:0] dd, input logic [3:0] dr, output int lat, output logic held);
    logic [7:0] q0;
    logic [3:0] r0;
    q0 = Q;
    r0 = R;
    held = 1'b1;
    @(negedge clk);
    DD = dd; DR = dr; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (Q !== q0 || R !== r0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({Q, R, busy, done, div_by_zero, zero} !== 16'd0) begin errors++;
      $display("FAIL reset_outputs got Q=%0d R=%0d busy=%b done=%b dbz=%b zero=%b want all 0", Q, R, busy, done, div_by_zero, zero); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_directed;
    logic [7:0] dds [6] = '{8'd100, 8'd255, 8'd255, 8'd5, 8'd0, 8'd200};
    logic [3:0] drs [6] = '{4'd7, 4'd1, 4'd15, 4'd9, 4'd3, 4'd13};
    int lat;
    logic held;
    for (int i = 0; i < 6; i++) begin
      run(dds[i], drs[i], lat, held);
      checks++; if (lat !== 17) begin errors++;
        $display("FAIL dir_latency %0d/%0d got %0d want 17", dds[i], drs[i], lat); end
      checks++; if (Q !== 8'(exp_q(dds[i], drs[i])) || R !== 4'(exp_r(dds[i], drs[i]))) begin errors++;
        $display("FAIL dir_result %0d/%0d got Q=%0d R=%0d want Q=%0d R=%0d", dds[i], drs[i], Q, R, exp_q(dds[i], drs[i]), exp_r(dds[i], drs[i])); end
      checks++; if (zero !== (exp_q(dds[i], drs[i]) == 0) || div_by_zero !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL dir_flags %0d/%0d got zero=%b dbz=%b busy=%b", dds[i], drs[i], zero, div_by_zero, busy); end
      checks++; if (!held) begin errors++;
        $display("FAIL dir_hold %0d/%0d Q/R changed before END1 got 0 want 1", dds[i], drs[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic held;
    run(8'd42, 4'd0, lat, held);
    checks++; if (lat !== 1) begin errors++;
      $display("FAIL dbz_latency got %0d want 1", lat); end
    checks++; if (Q !== 8'hFF || R !== 4'd0 || div_by_zero !== 1'b1 || zero !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL dbz_result got Q=%0d R=%0d dbz=%b zero=%b busy=%b want 255 0 1 0 0", Q, R, div_by_zero, zero, busy); end
  endtask

  task automatic test_init_while_busy;
    int lat;
    @(negedge clk);
    DD = 8'd200; DR = 4'd13; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL busy_start got busy=%b done=%b want 1 0", busy, done); end
    repeat (3) @(posedge clk);
    @(negedge clk); DD = 8'd77; DR = 4'd2; init = 1'b1;
    @(negedge clk); init = 1'b0; DD = 8'd9; DR = 4'd0;
    lat = 4;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 17 || Q !== 8'd15 || R !== 4'd5) begin errors++;
      $display("FAIL busy_ignore got lat=%0d Q=%0d R=%0d want 17 15 5", lat, Q, R); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL busy_idle got busy=%b done=%b want 0 1", busy, done); end
  endtask

  task automatic test_async_reset;
    int lat;
    logic held;
    @(negedge clk);
    DD = 8'd123; DR = 4'd4; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({Q, R, busy, done, div_by_zero, zero} !== 16'd0) begin errors++;
      $display("FAIL async_reset got Q=%0d R=%0d busy=%b done=%b dbz=%b zero=%b want all 0", Q, R, busy, done, div_by_zero, zero); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_abort got done=%b busy=%b want 0 0", done, busy); end
    run(8'd123, 4'd4, lat, held);
    checks++; if (lat !== 17 || Q !== 8'd30 || R !== 4'd3) begin errors++;
      $display("FAIL restart got lat=%0d Q=%0d R=%0d want 17 30 3", lat, Q, R); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    DD = 8'd50; DR = 4'd6; init = 1'b1;
    @(posedge clk); #1;
    DD = 8'd99; DR = 4'd10;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 17 || Q !== 8'd8 || R !== 4'd2) begin errors++;
      $display("FAIL b2b_first got lat=%0d Q=%0d R=%0d want 17 8 2", lat, Q, R); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL b2b_restart got done=%b busy=%b want 0 1", done, busy); end
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    init = 1'b0;
    checks++; if (lat !== 17 || Q !== 8'd9 || R !== 4'd9) begin errors++;
      $display("FAIL b2b_second got lat=%0d Q=%0d R=%0d want 17 9 9", lat, Q, R); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat;
    logic held;
    logic [7:0] dd;
    logic [3:0] dr;
    for (int i = 0; i < 40; i++) begin
      dd = 8'($urandom_range(0, 255));
      dr = 4'($urandom_range(0, 15));
      run(dd, dr, lat, held);
      checks++; if (lat !== (dr == 0 ? 1 : 17)) begin errors++;
        $display("FAIL rnd_latency %0d/%0d got %0d want %0d", dd, dr, lat, dr == 0 ? 1 : 17); end
      checks++; if (Q !== 8'(exp_q(dd, dr)) || R !== 4'(exp_r(dd, dr)) || div_by_zero !== (dr == 0)) begin errors++;
        $display("FAIL rnd_result %0d/%0d got Q=%0d R=%0d dbz=%b want Q=%0d R=%0d", dd, dr, Q, R, div_by_zero, exp_q(dd, dr), exp_r(dd, dr)); end
      if (dr != 0) begin
        checks++; if (int'(Q) * int'(dr) + int'(R) != int'(dd) || R >= dr) begin errors++;
          $display("FAIL rnd_identity %0d/%0d got Q=%0d R=%0d want DD=Q*DR+R and R<DR", dd, dr, Q, R); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_init_while_busy;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
